rx_engine_mfilt: RTL and testbench

Parametrised next-generation raw Ethernet receive engine. It takes a byte-wide GMII-style stream and checks preamble, SFD, destination MAC, length and CRC. Destination MAC is matched against NUM_FILT programmable unicast entries plus broadcast/multicast/promiscuous modes. Accepted bytes are packed into 36-bit words for the rx data FIFO, and a length/status entry goes to the rx frame queue, with per-reason saturating drop counters.

---
 rtl/rx_engine_mfilt.sv | 233 +++++++++++++++++++++++
 tb/tb_rx_engine_mfilt.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_engine_mfilt.sv
// Byte-wide raw Ethernet receive engine with DMAC filtering. It packs accepted
// bytes into 36-bit FIFO words and posts a length/status entry for each frame.
module rx_engine_mfilt #(
  parameter int NUM_FILT  = 4,
  parameter int LEN_W     = 14,
  parameter int MAX_STD   = 1522,
  parameter int MAX_JUMBO = 9022,
  parameter int MIN_LEN   = 64,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   promiscuous,
  input  logic                   accept_mcast,
  input  logic                   jumboframes,
  input  logic [48*NUM_FILT-1:0] filt_addr,
  input  logic [NUM_FILT-1:0]    filt_en,
  input  logic [7:0]             rx_din,
  input  logic                   rx_dv,
  input  logic                   rx_er,
  output logic                   crc_init,
  output logic [7:0]             crc_data,
  input  logic                   crc_good,
  output logic [35:0]            rxff_din,
  output logic                   rxff_we,
  input  logic                   rxff_almost_full,
  output logic [LEN_W+2:0]       rfq_din,
  output logic                   rfq_we,
  input  logic                   rfq_ready,
  output logic [31:0]            rx_count,
  output logic [CNT_W-1:0]       drop_err,
  output logic [CNT_W-1:0]       drop_filt,
  output logic [CNT_W-1:0]       drop_ovf
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DMAC, DMAC_CHK, DATA, DROP} state_t;

  // count includes the two pad bytes, so limits are offset by the pad slot
  localparam logic [LEN_W-1:0] STD_CNT   = LEN_W'(MAX_STD + 1);
  localparam logic [LEN_W-1:0] JUMBO_CNT = LEN_W'(MAX_JUMBO + 1);
  localparam logic [LEN_W-1:0] MIN_CNT   = LEN_W'(MIN_LEN + 2);

  state_t            state, nxt;
  logic [47:0]       dmac;
  logic [LEN_W-1:0]  count;
  logic [7:0]        hold;
  logic [1:0]        lane;
  logic [35:0]       acc;
  logic [35:0]       packed_word;
  logic              pend;
  logic              f_mcast, f_bcast, f_hit;

  logic              in_frame, is_bcast, is_ig, uni_hit, filt_ok;
  logic [LEN_W-1:0]  lim;
  logic              commit, commit_eof, load, start, shift_dmac, latch_flags;
  logic              close, accept, inc_err, inc_filt, inc_ovf;
  logic [7:0]        load_byte;

  assign crc_init = (state == PREAMBLE);
  assign crc_data = rx_din;

  assign is_bcast = &dmac;
  assign is_ig    = dmac[40];
  assign filt_ok  = promiscuous | is_bcast | (accept_mcast & is_ig) | uni_hit;
  assign lim      = jumboframes ? JUMBO_CNT : STD_CNT;
  assign in_frame = (state == PREAMBLE) || (state == DMAC) ||
                    (state == DMAC_CHK) || (state == DATA);

  always_comb begin
    uni_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_FILT; i++)
      if (filt_en[i] && (filt_addr[48*i +: 48] == dmac)) uni_hit = 1'b1;
  end

  // Each byte is held one cycle before entering a lane, so its eof bit is
  // known when it is placed; a drop marks the held byte as the final one.
  always_comb begin
    nxt         = state;
    commit      = 1'b0;
    commit_eof  = 1'b0;
    load        = 1'b0;
    load_byte   = rx_din;
    start       = 1'b0;
    shift_dmac  = 1'b0;
    latch_flags = 1'b0;
    close       = 1'b0;
    accept      = 1'b0;
    inc_err     = 1'b0;
    inc_filt    = 1'b0;
    inc_ovf     = 1'b0;
    if (in_frame) begin
      if (!rx_dv) begin
        close      = 1'b1;
        commit     = 1'b1;
        commit_eof = 1'b1;
        nxt        = IDLE;
        if ((state == DATA) && (count >= MIN_CNT) && crc_good) accept  = 1'b1;
        else                                                   inc_err = 1'b1;
      end else if (rx_er || rxff_almost_full) begin
        close      = 1'b1;
        commit     = 1'b1;
        commit_eof = 1'b1;
        nxt        = DROP;
        inc_err    = rx_er;
        inc_ovf    = ~rx_er;
      end else begin
        case (state)
          PREAMBLE: if (rx_din == 8'hD5) begin
            commit    = 1'b1;
            load      = 1'b1;
            load_byte = 8'h00;
            nxt       = DMAC;
          end
          DMAC: begin
            commit     = 1'b1;
            load       = 1'b1;
            shift_dmac = 1'b1;
            if (count == LEN_W'(7)) nxt = DMAC_CHK;
          end
          DMAC_CHK: begin
            commit = 1'b1;
            if (!filt_ok) begin
              close      = 1'b1;
              commit_eof = 1'b1;
              inc_filt   = 1'b1;
              nxt        = DROP;
            end else begin
              load        = 1'b1;
              latch_flags = 1'b1;
              nxt         = DATA;
            end
          end
          default: begin
            commit = 1'b1;
            if (count > lim) begin
              close      = 1'b1;
              commit_eof = 1'b1;
              inc_err    = 1'b1;
              nxt        = DROP;
            end else begin
              load = 1'b1;
            end
          end
        endcase
      end
    end else if (state == IDLE) begin
      if (rx_dv) begin
        if ((rx_din == 8'h55) && rfq_ready && !pend && !rxff_almost_full) begin
          start     = 1'b1;
          load      = 1'b1;
          load_byte = 8'h00;
          nxt       = PREAMBLE;
        end else begin
          inc_ovf = (rx_din == 8'h55);
          nxt     = DROP;
        end
      end
    end else if (!rx_dv) begin
      nxt = IDLE;
    end
  end

  always_comb begin
    packed_word = acc;
    case (lane)
      2'd0:    packed_word[35:27] = {commit_eof, hold};
      2'd1:    packed_word[26:18] = {commit_eof, hold};
      2'd2:    packed_word[17:9]  = {commit_eof, hold};
      default: packed_word[8:0]   = {commit_eof, hold};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dmac      <= '0;
      count     <= '0;
      hold      <= '0;
      lane      <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      f_mcast   <= 1'b0;
      f_bcast   <= 1'b0;
      f_hit     <= 1'b0;
      rxff_din  <= '0;
      rxff_we   <= 1'b0;
      rfq_din   <= '0;
      rfq_we    <= 1'b0;
      rx_count  <= '0;
      drop_err  <= '0;
      drop_filt <= '0;
      drop_ovf  <= '0;
    end else begin
      state   <= nxt;
      rxff_we <= 1'b0;
      rfq_we  <= 1'b0;
      if (load) begin
        hold  <= load_byte;
        count <= start ? LEN_W'(1) : count + LEN_W'(1);
      end
      if (shift_dmac) dmac <= {dmac[39:0], rx_din};
      if (latch_flags) begin
        f_mcast <= is_ig & ~is_bcast;
        f_bcast <= is_bcast;
        f_hit   <= uni_hit;
      end
      if (commit) begin
        if (commit_eof || (lane == 2'd3)) begin
          rxff_din <= packed_word;
          rxff_we  <= 1'b1;
          acc      <= '0;
          lane     <= '0;
        end else begin
          acc  <= packed_word;
          lane <= lane + 2'd1;
        end
      end
      if (pend && rfq_ready) begin
        rfq_we <= 1'b1;
        pend   <= 1'b0;
      end
      if (close) begin
        pend    <= 1'b1;
        rfq_din <= accept ? {f_mcast, f_bcast, f_hit, count - LEN_W'(6)} : '0;
      end
      if (accept && (rx_count != '1)) rx_count <= rx_count + 32'd1;
      if (inc_err && (drop_err != '1))   drop_err  <= drop_err + CNT_W'(1);
      if (inc_filt && (drop_filt != '1)) drop_filt <= drop_filt + CNT_W'(1);
      if (inc_ovf && (drop_ovf != '1))   drop_ovf  <= drop_ovf + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_engine_mfilt.sv
// Directed bench for rx_engine_mfilt: frames driven byte by byte, FIFO words
// and frame-queue entries collected by a monitor and compared to hand values.
module tb_rx_engine_mfilt;
  localparam int NUM_FILT = 4;
  localparam int LEN_W    = 14;
  localparam int CNT_W    = 16;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   promiscuous, accept_mcast, jumboframes;
  logic [48*NUM_FILT-1:0] filt_addr;
  logic [NUM_FILT-1:0]    filt_en;
  logic [7:0]             rx_din;
  logic                   rx_dv, rx_er;
  logic                   crc_init;
  logic [7:0]             crc_data;
  logic                   crc_good;
  logic [35:0]            rxff_din;
  logic                   rxff_we, rxff_almost_full;
  logic [LEN_W+2:0]       rfq_din;
  logic                   rfq_we, rfq_ready;
  logic [31:0]            rx_count;
  logic [CNT_W-1:0]       drop_err, drop_filt, drop_ovf;

  always #5 clk = ~clk;

  rx_engine_mfilt #(.NUM_FILT(NUM_FILT), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .promiscuous(promiscuous),
    .accept_mcast(accept_mcast), .jumboframes(jumboframes),
    .filt_addr(filt_addr), .filt_en(filt_en), .rx_din(rx_din), .rx_dv(rx_dv),
    .rx_er(rx_er), .crc_init(crc_init), .crc_data(crc_data),
    .crc_good(crc_good), .rxff_din(rxff_din), .rxff_we(rxff_we),
    .rxff_almost_full(rxff_almost_full), .rfq_din(rfq_din), .rfq_we(rfq_we),
    .rfq_ready(rfq_ready), .rx_count(rx_count), .drop_err(drop_err),
    .drop_filt(drop_filt), .drop_ovf(drop_ovf)
  );

  int          total = 0;
  int          passes = 0;
  int          words = 0, eofw = 0, rfqs = 0;
  int          w0, e0, r0;
  logic [35:0] last_word = '0, first_word = '0;
  logic [16:0] last_rfq = '0;
  logic        open_f = 1'b0;
  logic        chk_init = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) open_f <= 1'b0;
    else if (rxff_we) begin
      words     <= words + 1;
      last_word <= rxff_din;
      if (!open_f) first_word <= rxff_din;
      if (rxff_din[35] | rxff_din[26] | rxff_din[17] | rxff_din[8]) begin
        eofw   <= eofw + 1;
        open_f <= 1'b0;
      end else begin
        open_f <= 1'b1;
      end
    end
    if (rfq_we) begin
      rfqs     <= rfqs + 1;
      last_rfq <= rfq_din;
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  task automatic mark();
    @(negedge clk);
    w0 = words; e0 = eofw; r0 = rfqs;
  endtask

  task automatic send(input int len, input logic [47:0] da, input logic crc_ok,
                      input int af_at, input int rst_at);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rx_dv  = 1'b1;
      rx_din = 8'h55;
      if (chk_init && i == 2) begin
        check("crc_init", crc_init, 1);
        check("crc_data", crc_data, 8'h55);
      end
    end
    @(negedge clk);
    rx_din = 8'hD5;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rx_din           = (i < 6) ? da[47-8*i -: 8] : i[7:0];
      rxff_almost_full = (i == af_at);
      reset_n          = (i != rst_at);
    end
    @(negedge clk);
    rx_dv            = 1'b0;
    rx_din           = 8'h00;
    crc_good         = crc_ok;
    rxff_almost_full = 1'b0;
    reset_n          = 1'b1;
    @(negedge clk);
    crc_good = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  localparam logic [47:0] DA_HIT   = 48'h020000000012;
  localparam logic [47:0] DA_BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] DA_MCAST = 48'h01005E000001;

  initial begin
    reset_n = 1'b0; promiscuous = 1'b0; accept_mcast = 1'b0; jumboframes = 1'b0;
    for (int i = 0; i < NUM_FILT; i++) filt_addr[48*i +: 48] = 48'h020000000010 + 48'(i);
    filt_en = 4'b0100;
    rx_din = '0; rx_dv = 1'b0; rx_er = 1'b0; crc_good = 1'b0;
    rxff_almost_full = 1'b0; rfq_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rxff_we", rxff_we, 0);
    check("rst_rfq_we", rfq_we, 0);
    check("rst_rfq_din", rfq_din, 0);
    check("rst_rxff_din", rxff_din, 0);
    check("rst_counters", {rx_count, drop_err, drop_filt, drop_ovf}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 64-byte unicast hit on entry 2
    mark(); chk_init = 1'b1;
    send(64, DA_HIT, 1'b1, -1, -1);
    chk_init = 1'b0;
    check("t1_words", words - w0, 17);
    check("t1_eofw", eofw - e0, 1);
    check("t1_first", first_word, {1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 8'h00});
    check("t1_last", last_word[35:18], {1'b0, 8'h3E, 1'b1, 8'h3F});
    check("t1_rfqs", rfqs - r0, 1);
    check("t1_rfq", last_rfq, 17'h0403C);
    check("t1_rx_count", rx_count, 1);

    // 40-byte runt
    mark();
    send(40, DA_HIT, 1'b1, -1, -1);
    check("t2_words", words - w0, 11);
    check("t2_last", last_word[26:18], 9'h127);
    check("t2_rfq", last_rfq, 0);
    check("t2_drop_err", drop_err, 1);
    check("t2_rx_count", rx_count, 1);

    // bad CRC, then good broadcast
    mark();
    send(100, DA_HIT, 1'b0, -1, -1);
    check("t3_rfqs", rfqs - r0, 1);
    check("t3_rfq", last_rfq, 0);
    check("t3_drop_err", drop_err, 2);
    send(100, DA_BCAST, 1'b1, -1, -1);
    check("t3_bc_len", last_rfq[13:0], 96);
    check("t3_bc_flag", last_rfq[15:14], 2'b10);
    check("t3_rx_count", rx_count, 2);

    // multicast rejected, then accepted
    mark();
    send(64, DA_MCAST, 1'b1, -1, -1);
    check("t4_words", words - w0, 2);
    check("t4_last", last_word[8:0], 9'h101);
    check("t4_rfq", last_rfq, 0);
    check("t4_drop_filt", drop_filt, 1);
    accept_mcast = 1'b1;
    send(64, DA_MCAST, 1'b1, -1, -1);
    accept_mcast = 1'b0;
    check("t4_rfq_acc", last_rfq, 17'h1003C);
    check("t4_rx_count", rx_count, 3);

    // 9018-byte frame, standard then jumbo limit
    mark();
    send(9018, DA_HIT, 1'b1, -1, -1);
    check("t5_words", words - w0, 381);
    check("t5_last", last_word[8:0], 9'h1F1);
    check("t5_rfq", last_rfq, 0);
    check("t5_drop_err", drop_err, 3);
    jumboframes = 1'b1;
    mark();
    send(9018, DA_HIT, 1'b1, -1, -1);
    jumboframes = 1'b0;
    check("t5j_words", words - w0, 2255);
    check("t5j_last", last_word[8:0], 9'h139);
    check("t5j_rfq", last_rfq, 17'h06336);
    check("t5j_rx_count", rx_count, 4);

    // FIFO almost full at byte 30
    mark();
    send(64, DA_HIT, 1'b1, 29, -1);
    check("t6_words", words - w0, 8);
    check("t6_last", last_word[17:9], 9'h11C);
    check("t6_rfqs", rfqs - r0, 1);
    check("t6_rfq", last_rfq, 0);
    check("t6_drop_ovf", drop_ovf, 1);
    check("t6_drop_err", drop_err, 3);

    // frame queue not ready at frame start
    rfq_ready = 1'b0;
    mark();
    send(64, DA_HIT, 1'b1, -1, -1);
    rfq_ready = 1'b1;
    check("t7_words", words - w0, 0);
    check("t7_rfqs", rfqs - r0, 0);
    check("t7_drop_ovf", drop_ovf, 2);

    // reset mid-frame, then a good frame
    mark();
    send(64, DA_HIT, 1'b1, -1, 20);
    check("t8_rfqs", rfqs - r0, 0);
    check("t8_counters", {rx_count, drop_err, drop_filt, drop_ovf}, 0);
    mark();
    send(64, DA_HIT, 1'b1, -1, -1);
    check("t8_words", words - w0, 17);
    check("t8_rfq", last_rfq, 17'h0403C);
    check("t8_rx_count", rx_count, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
